// File: rtl/serial_work_initiator_if.sv
// Command, UART byte-stream and outcome signals between a controller and serial_work_initiator.
// slave is the initiator's view; master is the controller/UART side.
interface serial_work_initiator_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_type;
  logic [639:0] cmd_data;
  logic [7:0]   tx_data;
  logic         new_tx_data;
  logic         tx_busy;
  logic [7:0]   rx_data;
  logic         new_rx_data;
  logic         cmd_done;
  logic [2:0]   cmd_status;
  logic [31:0]  info_data;
  logic         result_valid;
  logic [31:0]  result_data;

  modport slave (
    input  cmd_valid, cmd_type, cmd_data, tx_busy, rx_data, new_rx_data,
    output cmd_ready, tx_data, new_tx_data, cmd_done, cmd_status, info_data,
           result_valid, result_data
  );

  modport master (
    output cmd_valid, cmd_type, cmd_data, tx_busy, rx_data, new_rx_data,
    input  cmd_ready, tx_data, new_tx_data, cmd_done, cmd_status, info_data,
           result_valid, result_data
  );
endinterface

// File: rtl/serial_work_initiator.sv
// Serialises one [type][len][value] command frame to a UART tx and reports the reply outcome.
// Latency: byte strobe one cycle after SEND sees !tx_busy; outcomes one cycle after the final rx byte.
// Backpressure: cmd_ready only in IDLE; tx_busy stalls SEND. SERIAL_INIT_RETRY_EN enables timeout retries.
module serial_work_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_work_initiator_if.slave bus
);

  localparam logic [7:0]  T_ACK       = 8'd2;
  localparam logic [7:0]  T_NACK      = 8'd4;
  localparam logic [7:0]  T_INFO      = 8'd18;
  localparam logic [7:0]  T_NEW_WORK  = 8'd19;
  localparam logic [7:0]  T_TEST_WORK = 8'd21;
  localparam logic [7:0]  T_RESULT    = 8'd32;
  localparam logic [7:0]  T_ERROR     = 8'd254;

  localparam logic [2:0]  ST_ACK      = 3'd0;
  localparam logic [2:0]  ST_NACK     = 3'd1;
  localparam logic [2:0]  ST_ERROR    = 3'd2;
  localparam logic [2:0]  ST_INFO     = 3'd3;
  localparam logic [2:0]  ST_TIMEOUT  = 3'd4;
  localparam logic [2:0]  ST_UNEXP    = 3'd5;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP, TX_WAIT} tx_state_t;
  typedef enum logic [1:0] {RX_TYPE, RX_LEN, RX_VALUE} rx_state_t;

  tx_state_t    tx_state, tx_state_nxt;
  rx_state_t    rx_state, rx_state_nxt;

  logic [7:0]   type_q;
  logic [6:0]   len_q;
  logic [639:0] data_q;
  logic [6:0]   byte_idx;
  logic [31:0]  timer;
  logic [7:0]   tx_data_q;
  logic         new_tx_q;

  logic [7:0]   rx_type_q;
  logic [7:0]   rx_len_q;
  logic [7:0]   rx_cnt_q;
  logic [31:0]  rx_val_q;

  logic         cmd_done_q;
  logic [2:0]   cmd_status_q;
  logic [31:0]  info_q;
  logic         result_valid_q;
  logic [31:0]  result_q;

  logic         accept;
  logic         strobe;
  logic         last_byte;
  logic         expire;
  logic         retry;
  logic         frame_done;
  logic         reply_done;
  logic         timeout_fire;
  logic [7:0]   tx_byte;
  logic [7:0]   done_type;
  logic [31:0]  val_merge;
  logic [31:0]  done_val;
  logic [2:0]   reply_status;
  logic [9:0]   pay_bit;

  assign accept       = (tx_state == TX_IDLE) && bus.cmd_valid && !rst;
  assign strobe       = (tx_state == TX_SEND) && !bus.tx_busy;
  assign last_byte    = (byte_idx == len_q + 7'd1);
  assign expire       = (timer == TIMEOUT_LAST);
  assign reply_done   = frame_done && (done_type != T_RESULT) && (tx_state == TX_WAIT);
  assign timeout_fire = (tx_state == TX_WAIT) && expire && !reply_done;

`ifdef SERIAL_INIT_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);
  logic [RETRY_W-1:0] retry_cnt;

  assign retry = (retry_cnt < RETRY_W'(MAX_RETRIES));

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (accept) begin
      retry_cnt <= '0;
    end else if (timeout_fire && retry) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  logic unused_max_retries;
  assign unused_max_retries = (MAX_RETRIES != 0);
  assign retry = 1'b0;
`endif

  // Byte 0 is the type, byte 1 the length, then payload bytes 0..len-1.
  assign pay_bit = {byte_idx - 7'd2, 3'b000};

  always_comb begin
    case (byte_idx)
      7'd0:    tx_byte = type_q;
      7'd1:    tx_byte = {1'b0, len_q};
      default: tx_byte = data_q[pay_bit +: 8];
    endcase
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE: if (bus.cmd_valid) tx_state_nxt = TX_SEND;
      TX_SEND: if (!bus.tx_busy) tx_state_nxt = TX_GAP;
      TX_GAP:  tx_state_nxt = last_byte ? TX_WAIT : TX_SEND;
      TX_WAIT: begin
        if (reply_done) begin
          tx_state_nxt = TX_IDLE;
        end else if (expire) begin
          tx_state_nxt = retry ? TX_SEND : TX_IDLE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Only the first four value bytes are kept; missing ones stay zero from the TYPE clear.
  always_comb begin
    val_merge = rx_val_q;
    if (rx_cnt_q < 8'd4) begin
      val_merge[{rx_cnt_q[1:0], 3'b000} +: 8] = bus.rx_data;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    frame_done   = 1'b0;
    done_type    = rx_type_q;
    done_val     = rx_val_q;
    if (bus.new_rx_data) begin
      case (rx_state)
        RX_TYPE: rx_state_nxt = RX_LEN;
        RX_LEN: begin
          if (bus.rx_data == 8'd0) begin
            frame_done   = 1'b1;
            rx_state_nxt = RX_TYPE;
          end else begin
            rx_state_nxt = RX_VALUE;
          end
        end
        RX_VALUE: begin
          done_val = val_merge;
          if (rx_cnt_q == rx_len_q - 8'd1) begin
            frame_done   = 1'b1;
            rx_state_nxt = RX_TYPE;
          end
        end
        default: rx_state_nxt = RX_TYPE;
      endcase
    end
  end

  always_comb begin
    case (done_type)
      T_ACK:   reply_status = ST_ACK;
      T_NACK:  reply_status = ST_NACK;
      T_ERROR: reply_status = ST_ERROR;
      T_INFO:  reply_status = ST_INFO;
      default: reply_status = ST_UNEXP;
    endcase
  end

  // A timeout abandons any partially received frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_TYPE;
    end else begin
      tx_state <= tx_state_nxt;
      rx_state <= timeout_fire ? RX_TYPE : rx_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_q    <= '0;
      len_q     <= '0;
      data_q    <= '0;
      byte_idx  <= '0;
      timer     <= '0;
      tx_data_q <= '0;
      new_tx_q  <= 1'b0;
    end else begin
      new_tx_q <= strobe;
      if (accept) begin
        type_q   <= bus.cmd_type;
        len_q    <= (bus.cmd_type == T_NEW_WORK || bus.cmd_type == T_TEST_WORK) ? 7'd80 : 7'd0;
        data_q   <= bus.cmd_data;
        byte_idx <= '0;
      end
      if (strobe) begin
        tx_data_q <= tx_byte;
      end
      if (tx_state == TX_GAP) begin
        if (last_byte) begin
          timer <= '0;
        end else begin
          byte_idx <= byte_idx + 7'd1;
        end
      end
      if (tx_state == TX_WAIT) begin
        timer <= timer + 32'd1;
      end
      if (timeout_fire && retry) begin
        byte_idx <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_type_q <= '0;
      rx_len_q  <= '0;
      rx_cnt_q  <= '0;
      rx_val_q  <= '0;
    end else if (bus.new_rx_data) begin
      case (rx_state)
        RX_TYPE: begin
          rx_type_q <= bus.rx_data;
          rx_val_q  <= '0;
        end
        RX_LEN: begin
          rx_len_q <= bus.rx_data;
          rx_cnt_q <= '0;
        end
        RX_VALUE: begin
          rx_val_q <= val_merge;
          rx_cnt_q <= rx_cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // A reply completing in the expiry cycle takes priority over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_done_q     <= 1'b0;
      cmd_status_q   <= '0;
      info_q         <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      cmd_done_q     <= 1'b0;
      result_valid_q <= 1'b0;
      if (reply_done) begin
        cmd_done_q   <= 1'b1;
        cmd_status_q <= reply_status;
        if (done_type == T_INFO) begin
          info_q <= done_val;
        end
      end else if (timeout_fire && !retry) begin
        cmd_done_q   <= 1'b1;
        cmd_status_q <= ST_TIMEOUT;
      end
      if (frame_done && done_type == T_RESULT) begin
        result_valid_q <= 1'b1;
        result_q       <= done_val;
      end
    end
  end

  assign bus.cmd_ready    = (tx_state == TX_IDLE) && !rst;
  assign bus.tx_data      = tx_data_q;
  assign bus.new_tx_data  = new_tx_q;
  assign bus.cmd_done     = cmd_done_q;
  assign bus.cmd_status   = cmd_status_q;
  assign bus.info_data    = info_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_data  = result_q;

endmodule

// File: tb/tb_serial_work_initiator.sv
// Directed, table-driven bench for serial_work_initiator with short timeout.
module tb_serial_work_initiator;
  localparam int TO   = 100;
  localparam int MAXR = 2;
`ifdef SERIAL_INIT_RETRY_EN
  localparam int ATTEMPTS = MAXR + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_work_initiator_if bus();

  serial_work_initiator #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  txq[$];
  int          tx_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [2:0]  done_status = '0;
  logic        ready_at_done = 1'b0;
  int          res_cnt = 0;
  logic [31:0] res_val = '0;
  int          busy_viol = 0;
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.new_tx_data) begin
      txq.push_back(bus.tx_data);
      tx_cyc.push_back(cyc);
      if (busy_prev) busy_viol++;
    end
    busy_prev = bus.tx_busy;
    if (bus.cmd_done) begin
      done_cnt++;
      done_cyc      = cyc;
      done_status   = bus.cmd_status;
      ready_at_done = bus.cmd_ready;
    end
    if (bus.result_valid) begin
      res_cnt++;
      res_val = bus.result_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] t, input logic [7:0] seed);
    int n = 0;
    while (!bus.cmd_ready && n < 2000) begin
      tick(1);
      n++;
    end
    chk("cmd_ready_before_accept", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_type = t;
    for (int i = 0; i < 80; i++) bus.cmd_data[8*i +: 8] = 8'(i) + seed;
    bus.cmd_valid = 1'b1;
    tick(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string name);
    int k = 0;
    while (txq.size() < n && k < 5000) begin
      tick(1);
      k++;
    end
    if (txq.size() < n) chk(name, 32'(txq.size()), 32'(n));
  endtask

  task automatic wait_done(input int tgt, input string name);
    int k = 0;
    while (done_cnt < tgt && k < 2000) begin
      tick(1);
      k++;
    end
    chk(name, 32'(done_cnt), 32'(tgt));
  endtask

  task automatic rx_bytes(input logic [63:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_data     = fr[63 - 8*i -: 8];
      bus.new_rx_data = 1'b1;
      tick(1);
    end
    bus.new_rx_data = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},    32'(bus.cmd_ready),    32'd0);
    chk({tag, "_new_tx_data"},  32'(bus.new_tx_data),  32'd0);
    chk({tag, "_tx_data"},      32'(bus.tx_data),      32'd0);
    chk({tag, "_cmd_done"},     32'(bus.cmd_done),     32'd0);
    chk({tag, "_cmd_status"},   32'(bus.cmd_status),   32'd0);
    chk({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_info_data"},    bus.info_data,         32'd0);
    chk({tag, "_result_data"},  bus.result_data,       32'd0);
  endtask

  typedef struct {
    logic [7:0]  ctype;
    logic [7:0]  seed;
    int          busy_at;
    logic [63:0] rx;
    int          rx_n;
    logic [2:0]  st;
    logic [31:0] info;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: actual=hung required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rbase, k, nbytes, bad, maxgap;
    logic [7:0] exp_b;

    vecs[0] = '{8'h08, 8'h00,  0, 64'h0200_0000_0000_0000, 2, 3'd0, 32'h0000_0000};
    vecs[1] = '{8'h13, 8'h00, 20, 64'h0400_0000_0000_0000, 2, 3'd1, 32'h0000_0000};
    vecs[2] = '{8'h12, 8'h00,  0, 64'h1204_4D6F_5633_0000, 6, 3'd3, 32'h3356_6F4D};
    vecs[3] = '{8'h14, 8'h00,  0, 64'hFE00_0000_0000_0000, 2, 3'd2, 32'h3356_6F4D};
    vecs[4] = '{8'h15, 8'h30,  5, 64'h0700_0000_0000_0000, 2, 3'd5, 32'h3356_6F4D};
    vecs[5] = '{8'h12, 8'h00,  0, 64'h1202_AABB_0000_0000, 4, 3'd3, 32'h0000_BBAA};
    vecs[6] = '{8'h12, 8'h00,  0, 64'h1206_0102_0304_0506, 8, 3'd3, 32'h0403_0201};
    vecs[7] = '{8'h55, 8'h00,  0, 64'h0200_0000_0000_0000, 2, 3'd0, 32'h0403_0201};

    bus.cmd_valid   = 1'b0;
    bus.cmd_type    = '0;
    bus.cmd_data    = '0;
    bus.tx_busy     = 1'b0;
    bus.rx_data     = '0;
    bus.new_rx_data = 1'b0;

    tick(2);
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick(1);
    chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    for (int v = 0; v < 8; v++) begin
      txq.delete();
      tx_cyc.delete();
      base   = done_cnt;
      nbytes = (vecs[v].ctype == 8'h13 || vecs[v].ctype == 8'h15) ? 82 : 2;
      send_cmd(vecs[v].ctype, vecs[v].seed);
      if (vecs[v].busy_at > 0) begin
        wait_tx(vecs[v].busy_at, $sformatf("v%0d_busy_start", v));
        bus.tx_busy = 1'b1;
        tick(10);
        bus.tx_busy = 1'b0;
      end
      wait_tx(nbytes, $sformatf("v%0d_tx_wait", v));
      chk($sformatf("v%0d_tx_count", v), 32'(txq.size()), 32'(nbytes));
      for (int i = 0; i < nbytes && i < txq.size(); i++) begin
        exp_b = (i == 0) ? vecs[v].ctype : (i == 1) ? 8'(nbytes - 2) : 8'(i - 2) + vecs[v].seed;
        chk($sformatf("v%0d_tx_byte%0d", v, i), 32'(txq[i]), 32'(exp_b));
      end
      bad    = 0;
      maxgap = 0;
      for (int i = 1; i < tx_cyc.size(); i++) begin
        if (tx_cyc[i] - tx_cyc[i-1] > maxgap) maxgap = tx_cyc[i] - tx_cyc[i-1];
        if (vecs[v].busy_at == 0 && tx_cyc[i] - tx_cyc[i-1] != 2) bad++;
        if (tx_cyc[i] - tx_cyc[i-1] < 2) bad++;
      end
      chk($sformatf("v%0d_strobe_spacing_bad", v), 32'(bad), 32'd0);
      if (vecs[v].busy_at > 0)
        chk($sformatf("v%0d_stall_gap_ge11", v), 32'(maxgap >= 11), 32'd1);
      rx_bytes(vecs[v].rx, vecs[v].rx_n);
      k = cyc;
      wait_done(base + 1, $sformatf("v%0d_done", v));
      chk($sformatf("v%0d_done_cycle", v), 32'(done_cyc), 32'(k));
      chk($sformatf("v%0d_status", v), 32'(done_status), 32'(vecs[v].st));
      chk($sformatf("v%0d_ready_with_done", v), 32'(ready_at_done), 32'd1);
      chk($sformatf("v%0d_info", v), bus.info_data, vecs[v].info);
      tick(4);
      chk($sformatf("v%0d_no_extra_tx", v), 32'(txq.size()), 32'(nbytes));
      chk($sformatf("v%0d_single_done", v), 32'(done_cnt), 32'(base + 1));
    end

    // RESULT while waiting for a reply, plus a command attempt while busy.
    txq.delete();
    base  = done_cnt;
    rbase = res_cnt;
    send_cmd(8'h08, 8'h00);
    wait_tx(2, "res_tx_wait");
    tick(2);
    bus.cmd_type  = 8'h14;
    bus.cmd_valid = 1'b1;
    tick(1);
    bus.cmd_valid = 1'b0;
    rx_bytes(64'h2004_EFBE_ADDE_0000, 6);
    tick(1);
    chk("res_pulse_count", 32'(res_cnt), 32'(rbase + 1));
    chk("res_data", res_val, 32'hDEAD_BEEF);
    chk("res_no_cmd_done", 32'(done_cnt), 32'(base));
    chk("busy_cmd_ignored", 32'(txq.size()), 32'd2);
    rx_bytes(64'h0200_0000_0000_0000, 2);
    k = cyc;
    wait_done(base + 1, "res_then_ack_done");
    chk("res_then_ack_status", 32'(done_status), 32'd0);
    chk("res_then_ack_cycle", 32'(done_cyc), 32'(k));

    // Idle: short RESULT reads missing bytes as zero; a stray ACK is dropped.
    rx_bytes(64'h2002_1122_0000_0000, 4);
    tick(1);
    chk("idle_res_count", 32'(res_cnt), 32'(rbase + 2));
    chk("idle_res_data", res_val, 32'h0000_2211);
    rx_bytes(64'h0200_0000_0000_0000, 2);
    tick(3);
    chk("idle_ack_dropped", 32'(done_cnt), 32'(base + 1));

    // Timeout (with a partial frame pending, which the timeout must flush).
    txq.delete();
    tx_cyc.delete();
    base = done_cnt;
    send_cmd(8'h14, 8'h00);
    wait_tx(2, "to_first_tx");
    tick(3);
    rx_bytes(64'h0200_0000_0000_0000, 1);
    wait_tx(2 * ATTEMPTS, "to_all_tx");
    wait_done(base + 1, "to_done");
    chk("to_status", 32'(done_status), 32'd4);
    chk("to_tx_count", 32'(txq.size()), 32'(2 * ATTEMPTS));
    chk("to_done_cycle", 32'(done_cyc), 32'(tx_cyc[tx_cyc.size()-1] + 1 + TO));
    bad = 0;
    for (int i = 0; i < txq.size(); i++) begin
      exp_b = (i % 2 == 0) ? 8'h14 : 8'h00;
      if (txq[i] !== exp_b) bad++;
    end
    chk("to_tx_bytes_bad", 32'(bad), 32'd0);
    txq.delete();
    send_cmd(8'h08, 8'h00);
    wait_tx(2, "after_to_tx");
    rx_bytes(64'h0200_0000_0000_0000, 2);
    k = cyc;
    wait_done(base + 2, "after_to_done");
    chk("after_to_status", 32'(done_status), 32'd0);
    chk("after_to_cycle", 32'(done_cyc), 32'(k));

    // Reset in the middle of a NEW_WORK payload.
    txq.delete();
    base = done_cnt;
    send_cmd(8'h13, 8'h00);
    wait_tx(7, "mid_tx_wait");
    rst = 1'b1;
    tick(1);
    chk_reset_outputs("mid_reset");
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("mid_ready_after", 32'(bus.cmd_ready), 32'd1);
    tick(20);
    chk("mid_tx_stopped", 32'(txq.size()), 32'd7);
    chk("mid_no_done", 32'(done_cnt), 32'(base));
    txq.delete();
    send_cmd(8'h08, 8'h00);
    wait_tx(2, "post_reset_tx");
    chk("post_reset_type", 32'(txq[0]), 32'h08);
    chk("post_reset_len", 32'(txq[1]), 32'h00);
    rx_bytes(64'h0200_0000_0000_0000, 2);
    wait_done(base + 1, "post_reset_done");
    chk("post_reset_status", 32'(done_status), 32'd0);

    chk("busy_violations", 32'(busy_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
